// File: rtl/reorder_buffer_pkg.sv
// Reorder buffer constants and per-entry layout.
package reorder_buffer_pkg;
  localparam int ROB_SIZE  = 16;
  localparam int ROB_POS_W = 4;
  localparam int ROB_CNT_W = ROB_POS_W + 1;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int REG_W     = 5;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic              is_br;
    logic              is_store;
    logic              pred_jump;
    logic              real_jump;
    logic              ready;
    logic [DATA_W-1:0] val;
    logic [ADDR_W-1:0] target;
  } rob_entry_t;

  function automatic logic [ROB_POS_W-1:0] pos_inc(
    input logic [ROB_POS_W-1:0] p,
    input logic                 en
  );
    return p + ROB_POS_W'(en);
  endfunction
endpackage

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: in-order
// commit, result capture, operand bypass, rollback.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  output logic                 rob_full,
  output logic [ROB_POS_W-1:0] rob_next_pos,
  input  logic                 issue,
  input  logic [REG_W-1:0]     issue_rd,
  input  logic                 issue_is_br,
  input  logic                 issue_is_store,
  input  logic                 issue_pred_jump,
  input  logic                 alu_valid,
  input  logic [ROB_POS_W-1:0] alu_pos,
  input  logic [DATA_W-1:0]    alu_val,
  input  logic                 alu_real_jump,
  input  logic [ADDR_W-1:0]    alu_target,
  input  logic                 lsb_valid,
  input  logic [ROB_POS_W-1:0] lsb_pos,
  input  logic [DATA_W-1:0]    lsb_val,
  input  logic [ROB_POS_W-1:0] q_rs1_pos,
  input  logic [ROB_POS_W-1:0] q_rs2_pos,
  output logic                 q_rs1_ready,
  output logic                 q_rs2_ready,
  output logic [DATA_W-1:0]    q_rs1_val,
  output logic [DATA_W-1:0]    q_rs2_val,
  output logic                 rob_commit,
  output logic [REG_W-1:0]     rob_commit_rd,
  output logic [DATA_W-1:0]    rob_commit_val,
  output logic [ROB_POS_W-1:0] rob_commit_rob_pos,
  output logic                 commit_store,
  output logic                 rollback,
  output logic [ADDR_W-1:0]    rollback_pc
);

  logic [ROB_POS_W-1:0] r_head;
  logic [ROB_POS_W-1:0] r_tail;
  logic [ROB_CNT_W-1:0] r_count;
  rob_entry_t           r_ent [ROB_SIZE];

  logic                 r_commit;
  logic [REG_W-1:0]     r_commit_rd;
  logic [DATA_W-1:0]    r_commit_val;
  logic [ROB_POS_W-1:0] r_commit_pos;
  logic                 r_commit_store;
  logic                 r_rollback;
  logic [ADDR_W-1:0]    r_rollback_pc;

  rob_entry_t w_hd;
  rob_entry_t w_new;
  logic       w_commit;
  logic       w_mispred;
  logic       w_issue;

  assign w_hd      = r_ent[r_head];
  assign w_commit  = (r_count != '0) && w_hd.ready;
  assign w_mispred = w_commit && w_hd.is_br &&
                     (w_hd.real_jump != w_hd.pred_jump);
  assign rob_full  = r_count == ROB_CNT_W'(ROB_SIZE);
  // A full buffer still takes an issue when the head frees its slot.
  assign w_issue   = issue && (!rob_full || w_commit);

  always_comb begin
    w_new           = '0;
    w_new.rd        = issue_rd;
    w_new.is_br     = issue_is_br;
    w_new.is_store  = issue_is_store;
    w_new.pred_jump = issue_pred_jump;
  end

  always_comb begin
    q_rs1_ready = r_ent[q_rs1_pos].ready;
    q_rs1_val   = r_ent[q_rs1_pos].val;
    if (alu_valid && alu_pos == q_rs1_pos) begin
      q_rs1_ready = 1'b1;
      q_rs1_val   = alu_val;
    end else if (lsb_valid && lsb_pos == q_rs1_pos) begin
      q_rs1_ready = 1'b1;
      q_rs1_val   = lsb_val;
    end
  end

  always_comb begin
    q_rs2_ready = r_ent[q_rs2_pos].ready;
    q_rs2_val   = r_ent[q_rs2_pos].val;
    if (alu_valid && alu_pos == q_rs2_pos) begin
      q_rs2_ready = 1'b1;
      q_rs2_val   = alu_val;
    end else if (lsb_valid && lsb_pos == q_rs2_pos) begin
      q_rs2_ready = 1'b1;
      q_rs2_val   = lsb_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_commit       <= 1'b0;
      r_commit_rd    <= '0;
      r_commit_val   <= '0;
      r_commit_pos   <= '0;
      r_commit_store <= 1'b0;
      r_rollback     <= 1'b0;
      r_rollback_pc  <= '0;
      for (int i = 0; i < ROB_SIZE; i++) r_ent[i] <= '0;
    end else if (!rdy) begin
      r_commit       <= 1'b0;
      r_commit_store <= 1'b0;
      r_rollback     <= 1'b0;
    end else begin
      r_commit       <= w_commit;
      r_commit_store <= w_commit && w_hd.is_store;
      r_rollback     <= w_mispred;
      if (w_commit) begin
        r_commit_rd  <= w_hd.rd;
        r_commit_val <= w_hd.val;
        r_commit_pos <= r_head;
      end
      if (w_mispred) begin
        r_rollback_pc <= w_hd.real_jump ? w_hd.target : w_hd.val;
        r_head        <= '0;
        r_tail        <= '0;
        r_count       <= '0;
        for (int i = 0; i < ROB_SIZE; i++) r_ent[i].ready <= 1'b0;
      end else begin
        if (lsb_valid) begin
          r_ent[lsb_pos].val   <= lsb_val;
          r_ent[lsb_pos].ready <= 1'b1;
        end
        if (alu_valid) begin
          r_ent[alu_pos].val       <= alu_val;
          r_ent[alu_pos].real_jump <= alu_real_jump;
          r_ent[alu_pos].target    <= alu_target;
          r_ent[alu_pos].ready     <= 1'b1;
        end
        // Issue last so a stale broadcast cannot mark a fresh entry ready.
        if (w_issue) r_ent[r_tail] <= w_new;
        r_head  <= pos_inc(r_head, w_commit);
        r_tail  <= pos_inc(r_tail, w_issue);
        r_count <= r_count + ROB_CNT_W'(w_issue)
                           - ROB_CNT_W'(w_commit);
      end
    end
  end

  assign rob_next_pos       = r_tail;
  assign rob_commit         = r_commit;
  assign rob_commit_rd      = r_commit_rd;
  assign rob_commit_val     = r_commit_val;
  assign rob_commit_rob_pos = r_commit_pos;
  assign commit_store       = r_commit_store;
  assign rollback           = r_rollback;
  assign rollback_pc        = r_rollback_pc;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed and random checks of reorder_buffer
// against a queue-based model of the buffer.
module tb_reorder_buffer;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        rob_full;
  logic [3:0]  rob_next_pos;
  logic        issue, issue_is_br, issue_is_store, issue_pred_jump;
  logic [4:0]  issue_rd;
  logic        alu_valid, alu_real_jump;
  logic [3:0]  alu_pos;
  logic [31:0] alu_val, alu_target;
  logic        lsb_valid;
  logic [3:0]  lsb_pos;
  logic [31:0] lsb_val;
  logic [3:0]  q_rs1_pos, q_rs2_pos;
  logic        q_rs1_ready, q_rs2_ready;
  logic [31:0] q_rs1_val, q_rs2_val;
  logic        rob_commit, commit_store, rollback;
  logic [4:0]  rob_commit_rd;
  logic [31:0] rob_commit_val, rollback_pc;
  logic [3:0]  rob_commit_rob_pos;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rob_full(rob_full), .rob_next_pos(rob_next_pos),
    .issue(issue), .issue_rd(issue_rd),
    .issue_is_br(issue_is_br), .issue_is_store(issue_is_store),
    .issue_pred_jump(issue_pred_jump),
    .alu_valid(alu_valid), .alu_pos(alu_pos), .alu_val(alu_val),
    .alu_real_jump(alu_real_jump), .alu_target(alu_target),
    .lsb_valid(lsb_valid), .lsb_pos(lsb_pos), .lsb_val(lsb_val),
    .q_rs1_pos(q_rs1_pos), .q_rs2_pos(q_rs2_pos),
    .q_rs1_ready(q_rs1_ready), .q_rs2_ready(q_rs2_ready),
    .q_rs1_val(q_rs1_val), .q_rs2_val(q_rs2_val),
    .rob_commit(rob_commit), .rob_commit_rd(rob_commit_rd),
    .rob_commit_val(rob_commit_val),
    .rob_commit_rob_pos(rob_commit_rob_pos),
    .commit_store(commit_store),
    .rollback(rollback), .rollback_pc(rollback_pc)
  );

  typedef struct {
    int          pos;
    logic [4:0]  rd;
    bit          br, st, pj, rj, rdy;
    logic [31:0] val, tgt;
  } ment_t;

  ment_t       mq[$];
  int          m_tail;
  bit          e_commit, e_store, e_rb;
  logic [4:0]  e_rd;
  logic [31:0] e_val, e_rbpc;
  logic [3:0]  e_pos;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_tail = 0;
    e_commit = 0; e_store = 0; e_rb = 0;
    e_rd = '0; e_val = '0; e_pos = '0; e_rbpc = '0;
  endtask

  task automatic model_step();
    bit    do_c, full;
    ment_t n;
    if (!rdy) begin
      e_commit = 0; e_store = 0; e_rb = 0;
      return;
    end
    do_c = mq.size() > 0 && mq[0].rdy;
    full = mq.size() == 16;
    e_commit = do_c;
    e_store  = do_c && mq[0].st;
    e_rb     = 0;
    if (do_c) begin
      e_rd = mq[0].rd; e_val = mq[0].val; e_pos = 4'(mq[0].pos);
      if (mq[0].br && mq[0].rj != mq[0].pj) begin
        e_rb   = 1;
        e_rbpc = mq[0].rj ? mq[0].tgt : mq[0].val;
        mq.delete();
        m_tail = 0;
        return;
      end
    end
    foreach (mq[i]) begin
      if (alu_valid && mq[i].pos == int'(alu_pos)) begin
        mq[i].rdy = 1; mq[i].val = alu_val;
        mq[i].rj = alu_real_jump; mq[i].tgt = alu_target;
      end
      if (lsb_valid && mq[i].pos == int'(lsb_pos)) begin
        mq[i].rdy = 1; mq[i].val = lsb_val;
      end
    end
    if (do_c) void'(mq.pop_front());
    if (issue && (!full || do_c)) begin
      n = '{pos: m_tail, rd: issue_rd, br: issue_is_br,
            st: issue_is_store, pj: issue_pred_jump,
            rj: 0, rdy: 0, val: '0, tgt: '0};
      mq.push_back(n);
      m_tail = (m_tail + 1) % 16;
    end
  endtask

  task automatic chk_query(input string tag, input logic [3:0] p,
                           input logic r_o, input logic [31:0] v_o);
    if (alu_valid && alu_pos == p) begin
      chk({tag, "_rdy"}, r_o, 1);
      chk({tag, "_val"}, v_o, alu_val);
    end else if (lsb_valid && lsb_pos == p) begin
      chk({tag, "_rdy"}, r_o, 1);
      chk({tag, "_val"}, v_o, lsb_val);
    end else begin
      foreach (mq[i]) if (mq[i].pos == int'(p)) begin
        chk({tag, "_rdy"}, r_o, mq[i].rdy);
        if (mq[i].rdy) chk({tag, "_val"}, v_o, mq[i].val);
      end
    end
  endtask

  task automatic step();
    #1;
    chk("full", rob_full, mq.size() == 16);
    chk("next_pos", rob_next_pos, m_tail);
    chk_query("q1", q_rs1_pos, q_rs1_ready, q_rs1_val);
    chk_query("q2", q_rs2_pos, q_rs2_ready, q_rs2_val);
    model_step();
    @(posedge clk);
    #1;
    chk("commit", rob_commit, e_commit);
    chk("commit_store", commit_store, e_store);
    chk("rollback", rollback, e_rb);
    if (e_commit) begin
      chk("commit_rd", rob_commit_rd, e_rd);
      chk("commit_val", rob_commit_val, e_val);
      chk("commit_pos", rob_commit_rob_pos, e_pos);
    end
    if (e_rb) chk("rollback_pc", rollback_pc, e_rbpc);
  endtask

  task automatic idle();
    rdy = 1; issue = 0; issue_rd = '0; issue_is_br = 0;
    issue_is_store = 0; issue_pred_jump = 0;
    alu_valid = 0; alu_pos = '0; alu_val = '0;
    alu_real_jump = 0; alu_target = '0;
    lsb_valid = 0; lsb_pos = '0; lsb_val = '0;
    q_rs1_pos = '0; q_rs2_pos = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    idle();
    #1;
    chk("rst_commit", rob_commit, 0);
    chk("rst_store", commit_store, 0);
    chk("rst_rollback", rollback, 0);
    chk("rst_full", rob_full, 0);
    chk("rst_next_pos", rob_next_pos, 0);
    chk("rst_rd", rob_commit_rd, 0);
    chk("rst_val", rob_commit_val, 0);
    chk("rst_pos", rob_commit_rob_pos, 0);
    chk("rst_pc", rollback_pc, 0);
    chk("rst_q1", q_rs1_ready, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic push(input logic [4:0] rd, input bit br,
                      input bit st, input bit pj);
    issue = 1; issue_rd = rd; issue_is_br = br;
    issue_is_store = st; issue_pred_jump = pj;
    step();
    issue = 0;
  endtask

  task automatic rand_inputs();
    int ac[$];
    int lc[$];
    int k;
    rdy = ($urandom % 8) != 0;
    issue = ($urandom % 3) != 0;
    issue_rd = 5'($urandom);
    issue_is_br = ($urandom % 4) == 0;
    issue_is_store = !issue_is_br && ($urandom % 4) == 0;
    issue_pred_jump = 1'($urandom);
    alu_valid = 0; lsb_valid = 0;
    foreach (mq[i]) if (!mq[i].rdy) ac.push_back(i);
    if (ac.size() > 0 && $urandom % 2 == 1) begin
      k = ac[$urandom % ac.size()];
      alu_valid = 1;
      alu_pos = 4'(mq[k].pos);
      alu_val = $urandom;
      alu_target = $urandom;
      alu_real_jump = mq[k].br ?
        (($urandom % 8) == 0 ? !mq[k].pj : mq[k].pj) : 1'($urandom);
    end
    foreach (mq[i]) if (!mq[i].rdy && !mq[i].br &&
                        !(alu_valid && int'(alu_pos) == mq[i].pos))
      lc.push_back(i);
    if (lc.size() > 0 && $urandom % 2 == 1) begin
      k = lc[$urandom % lc.size()];
      lsb_valid = 1;
      lsb_pos = 4'(mq[k].pos);
      lsb_val = $urandom;
    end
    q_rs1_pos = (alu_valid && $urandom % 2 == 1) ? alu_pos : 4'($urandom);
    q_rs2_pos = (lsb_valid && $urandom % 2 == 1) ? lsb_pos : 4'($urandom);
  endtask

  initial begin
    rst = 0;
    idle();
    do_reset();

    push(5'd5, 0, 0, 0);
    alu_valid = 1; alu_pos = 4'd0; alu_val = 32'h1234;
    step();
    alu_valid = 0;
    step();
    chk("t2_commit", rob_commit, 1);
    chk("t2_rd", rob_commit_rd, 5);
    chk("t2_val", rob_commit_val, 32'h1234);
    chk("t2_pos", rob_commit_rob_pos, 0);
    step();

    push(5'd7, 0, 0, 0);
    push(5'd8, 0, 0, 0);
    push(5'd9, 0, 0, 0);
    #2;
    rst = 0;
    #1;
    chk("mid_rst_next_pos", rob_next_pos, 0);
    chk("mid_rst_full", rob_full, 0);
    chk("mid_rst_commit", rob_commit, 0);
    do_reset();

    push(5'd1, 0, 0, 0);
    push(5'd2, 0, 1, 0);
    alu_valid = 1; alu_pos = 4'd1; alu_val = 32'hB;
    step();
    alu_pos = 4'd0; alu_val = 32'hA;
    step();
    alu_valid = 0;
    step();
    chk("ooo_pos0", rob_commit_rob_pos, 0);
    chk("ooo_val0", rob_commit_val, 32'hA);
    step();
    chk("ooo_pos1", rob_commit_rob_pos, 1);
    chk("ooo_val1", rob_commit_val, 32'hB);
    chk("ooo_store1", commit_store, 1);
    step();

    do_reset();
    for (int i = 0; i < 16; i++) push(5'(i + 1), 0, 0, 0);
    chk("fill_full", rob_full, 1);
    chk("fill_wrap", rob_next_pos, 0);
    alu_valid = 1; alu_pos = 4'd0; alu_val = 32'h55;
    step();
    alu_valid = 0;
    issue = 1; issue_rd = 5'd9;
    step();
    issue = 0;
    chk("full_commit", rob_commit, 1);
    chk("full_stays", rob_full, 1);
    chk("full_tail", rob_next_pos, 1);

    do_reset();
    for (int i = 0; i < 4; i++) push(5'(i + 1), 0, 0, 0);
    q_rs1_pos = 4'd3;
    alu_valid = 1; alu_pos = 4'd3; alu_val = 32'd7;
    q_rs2_pos = 4'd2;
    lsb_valid = 1; lsb_pos = 4'd2; lsb_val = 32'd9;
    #1;
    chk("byp_q1_rdy", q_rs1_ready, 1);
    chk("byp_q1_val", q_rs1_val, 7);
    chk("byp_q2_rdy", q_rs2_ready, 1);
    chk("byp_q2_val", q_rs2_val, 9);
    step();
    idle();
    step();

    do_reset();
    push(5'd0, 1, 0, 0);
    alu_valid = 1; alu_pos = 4'd0; alu_real_jump = 1;
    alu_target = 32'h100; alu_val = 32'h44;
    step();
    alu_valid = 0;
    issue = 1; issue_rd = 5'd3;
    step();
    issue = 0;
    chk("br_rollback", rollback, 1);
    chk("br_pc", rollback_pc, 32'h100);
    chk("br_commit", rob_commit, 1);
    chk("br_next_pos", rob_next_pos, 0);
    chk("br_full", rob_full, 0);
    step();

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      rand_inputs();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
